// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : PC, instruction-memory request and IF/ID register with skid buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  input  logic        flush,
  input  logic        ex_stall,
  output logic [15:0] imem_addr,
  output logic        imem_read,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] id_instruction,
  output logic [15:0] id_pc_next,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] buffer, buffer_n;
  logic [15:0] instr_n, pcn_n;
  logic        valid_n;
  logic [15:0] pc_inc;

  assign pc_inc    = pc + 16'd1;
  assign imem_addr = pc;
  assign imem_read = (state == RUN);

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    buffer_n = buffer;
    instr_n  = id_instruction;
    pcn_n    = id_pc_next;
    valid_n  = id_valid;

    if (pc_load) begin
      // Redirect: drop any returning or buffered word; cancel an open request via ABORT.
      pc_n    = pc_target;
      instr_n = NOP_WORD;
      valid_n = 1'b0;
      if ((state == RUN && !imem_ready) || state == ABORT) begin
        state_n = ABORT;
      end else begin
        state_n = RUN;
      end
    end else begin
      case (state)
        RUN: begin
          if (imem_ready) begin
            pc_n = pc_inc;
            // A flush occupies IF/ID like a stall, so the arriving word parks in the skid buffer.
            if (ex_stall || flush) begin
              buffer_n = imem_rdata;
              state_n  = HOLD;
            end else begin
              instr_n = imem_rdata;
              pcn_n   = pc_inc;
              valid_n = 1'b1;
            end
          end else if (!ex_stall) begin
            instr_n = NOP_WORD;
            pcn_n   = pc_inc;
            valid_n = 1'b0;
          end
        end
        HOLD: begin
          if (!ex_stall && !flush) begin
            instr_n = buffer;
            pcn_n   = pc;
            valid_n = 1'b1;
            state_n = RUN;
          end
        end
        ABORT: begin
          state_n = RUN;
          if (!ex_stall) begin
            instr_n = NOP_WORD;
            valid_n = 1'b0;
          end
        end
        default: state_n = RUN;
      endcase

      if (flush) begin
        instr_n = NOP_WORD;
        pcn_n   = id_pc_next;
        valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      pc             <= RESET_PC;
      buffer         <= 16'h0000;
      id_instruction <= NOP_WORD;
      id_pc_next     <= 16'h0000;
      id_valid       <= 1'b0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      buffer         <= buffer_n;
      id_instruction <= instr_n;
      id_pc_next     <= pcn_n;
      id_valid       <= valid_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : directed self-checking bench for fetch_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        flush;
  logic        ex_stall;
  logic [15:0] imem_addr;
  logic        imem_read;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] id_instruction;
  logic [15:0] id_pc_next;
  logic        id_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Memory content: each word is its address XOR a fixed pattern.
  assign imem_rdata = imem_addr ^ 16'hC3A5;

  fetch_stage #(.RESET_PC(16'h0000), .NOP_WORD(16'h0000)) dut (
    .clk(clk), .rst(rst), .pc_load(pc_load), .pc_target(pc_target),
    .flush(flush), .ex_stall(ex_stall), .imem_addr(imem_addr),
    .imem_read(imem_read), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .id_instruction(id_instruction), .id_pc_next(id_pc_next), .id_valid(id_valid)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full IF/ID + fetch-port check
  task automatic st(input string tag, input logic [15:0] e_instr, input logic [15:0] e_pcn,
                    input logic e_valid, input logic [15:0] e_addr, input logic e_read);
    chk({tag, ".instr"}, id_instruction, e_instr);
    chk({tag, ".pc_next"}, id_pc_next, e_pcn);
    chk({tag, ".valid"}, {15'd0, id_valid}, {15'd0, e_valid});
    chk({tag, ".addr"}, imem_addr, e_addr);
    chk({tag, ".read"}, {15'd0, imem_read}, {15'd0, e_read});
  endtask

  initial begin
    rst = 1'b1; pc_load = 1'b0; pc_target = 16'h0000;
    flush = 1'b0; ex_stall = 1'b0; imem_ready = 1'b0;
    #3;
    chk("reset.instr", id_instruction, 16'h0000);
    chk("reset.pc_next", id_pc_next, 16'h0000);
    chk("reset.valid", {15'd0, id_valid}, 16'h0000);
    chk("reset.addr", imem_addr, 16'h0000);

    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b1;
    #1;
    chk("first.addr", imem_addr, 16'h0000);
    chk("first.read", {15'd0, imem_read}, 16'h0001);

    // Zero-wait streaming
    tick(); st("zw0", 16'hC3A5, 16'h0001, 1'b1, 16'h0001, 1'b1);
    tick(); st("zw1", 16'hC3A4, 16'h0002, 1'b1, 16'h0002, 1'b1);
    tick(); st("zw2", 16'hC3A7, 16'h0003, 1'b1, 16'h0003, 1'b1);
    tick(); st("zw3", 16'hC3A6, 16'h0004, 1'b1, 16'h0004, 1'b1);
    tick(); st("zw4", 16'hC3A1, 16'h0005, 1'b1, 16'h0005, 1'b1);

    // Wait states at PC=5
    imem_ready = 1'b0;
    tick(); st("wait1", 16'h0000, 16'h0006, 1'b0, 16'h0005, 1'b1);
    tick(); st("wait2", 16'h0000, 16'h0006, 1'b0, 16'h0005, 1'b1);
    tick(); st("wait3", 16'h0000, 16'h0006, 1'b0, 16'h0005, 1'b1);
    imem_ready = 1'b1;
    tick(); st("wait_done", 16'hC3A0, 16'h0006, 1'b1, 16'h0006, 1'b1);
    tick(); st("run6", 16'hC3A3, 16'h0007, 1'b1, 16'h0007, 1'b1);
    tick(); st("run7", 16'hC3A2, 16'h0008, 1'b1, 16'h0008, 1'b1);

    // Downstream stall with word returning at PC=8
    ex_stall = 1'b1;
    tick(); st("stall1", 16'hC3A2, 16'h0008, 1'b1, 16'h0009, 1'b0);
    tick(); st("stall2", 16'hC3A2, 16'h0008, 1'b1, 16'h0009, 1'b0);
    ex_stall = 1'b0;
    tick(); st("release", 16'hC3AD, 16'h0009, 1'b1, 16'h0009, 1'b1);
    tick(); st("after_rel", 16'hC3AC, 16'h000A, 1'b1, 16'h000A, 1'b1);

    // Redirect to 3, then redirect again during a wait at PC=3
    pc_load = 1'b1; pc_target = 16'h0003;
    tick(); st("jmp3", 16'h0000, 16'h000A, 1'b0, 16'h0003, 1'b1);
    pc_load = 1'b0; imem_ready = 1'b0;
    tick(); st("wait_at3", 16'h0000, 16'h0004, 1'b0, 16'h0003, 1'b1);
    pc_load = 1'b1; pc_target = 16'h0040;
    tick(); st("abort", 16'h0000, 16'h0004, 1'b0, 16'h0040, 1'b0);
    pc_load = 1'b0; imem_ready = 1'b1;
    tick(); st("post_abort", 16'h0000, 16'h0004, 1'b0, 16'h0040, 1'b1);
    tick(); st("fetch40", 16'hC3E5, 16'h0041, 1'b1, 16'h0041, 1'b1);

    // PC wrap at 16'hFFFF
    pc_load = 1'b1; pc_target = 16'hFFFF;
    tick(); st("jmpFFFF", 16'h0000, 16'h0041, 1'b0, 16'hFFFF, 1'b1);
    pc_load = 1'b0;
    tick(); st("wrap", 16'h3C5A, 16'h0000, 1'b1, 16'h0000, 1'b1);

    // Flush while a word arrives: word kept and delivered next cycle
    flush = 1'b1;
    tick(); st("flush", 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b0);
    flush = 1'b0;
    tick(); st("post_flush", 16'hC3A5, 16'h0001, 1'b1, 16'h0001, 1'b1);

    // Async reset while in HOLD
    ex_stall = 1'b1;
    tick(); st("hold_pre_rst", 16'hC3A5, 16'h0001, 1'b1, 16'h0002, 1'b0);
    #2 rst = 1'b1;
    #1; st("async_rst", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
    ex_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick(); st("after_rst", 16'hC3A5, 16'h0001, 1'b1, 16'h0001, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
